transient_detector: RTL

//  Analysis/control side of the transient shaper. Tracks fast and slow envelopes of the 6-bit audio stream.

---
 rtl/transient_detector.sv | 107 ++++++++++
 1 files changed

// File: rtl/transient_detector.sv
// transient_detector: fast/slow envelope tracker and attack/sustain/release classifier for the transient shaper.
// Define TRANSIENT_DETECT_RETRIGGER_EN to let a new onset during ATTACK reload the hold timer and pulse onset.
module transient_detector #(
  parameter int WIDTH          = 8,
  parameter int ATTACK_THRESH  = 8,
  parameter int SUSTAIN_MIN    = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-3:0] audio_in,
  output logic             attack_amt,
  output logic             sustain_amt,
  output logic             onset,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] fast_env,
  output logic [WIDTH-1:0] slow_env
);
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [HW-1:0] HL = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RL = RW'(RELEASE_CYCLES - 1);
  localparam logic signed [WIDTH:0] TH = (WIDTH+1)'(ATTACK_THRESH);
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(SUSTAIN_MIN);
  state_t st;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rel_cnt;
  logic over_q;
  logic [WIDTH+2:0] fast_sum, slow_sum;
  logic signed [WIDTH:0] diff;
  logic over, trig;
  always_comb begin
    fast_sum = {3'b0, fast_env} * (WIDTH+3)'(3) + (WIDTH+3)'(audio_in);
    slow_sum = {3'b0, slow_env} * (WIDTH+3)'(7) + (WIDTH+3)'(audio_in);
    diff = $signed({1'b0, fast_env}) - $signed({1'b0, slow_env});
    over = diff >= TH;
    trig = over & ~over_q;
  end
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      hold_cnt <= '0;
      rel_cnt <= '0;
      over_q <= 1'b0;
      fast_env <= '0;
      slow_env <= '0;
      attack_amt <= 1'b0;
      sustain_amt <= 1'b0;
      onset <= 1'b0;
    end else begin
      onset <= 1'b0;
      if (ena) begin
        fast_env <= fast_sum[WIDTH+1:2];
        slow_env <= slow_sum[WIDTH+2:3];
        over_q <= over;
        case (st)
          IDLE: if (trig) begin
            st <= ATTACK;
            hold_cnt <= HL;
            onset <= 1'b1;
            attack_amt <= 1'b1;
          end
          ATTACK: begin
`ifdef TRANSIENT_DETECT_RETRIGGER_EN
            if (trig) begin
              hold_cnt <= HL;
              onset <= 1'b1;
            end else
`endif
            if (hold_cnt == '0) begin
              attack_amt <= 1'b0;
              if (slow_env >= SMIN) begin
                st <= SUSTAIN;
                sustain_amt <= 1'b1;
              end else begin
                st <= RELEASE;
                rel_cnt <= RL;
              end
            end else hold_cnt <= hold_cnt - 1'b1;
          end
          SUSTAIN: if (trig) begin
            st <= ATTACK;
            hold_cnt <= HL;
            onset <= 1'b1;
            attack_amt <= 1'b1;
            sustain_amt <= 1'b0;
          end else if (slow_env < SMIN) begin
            st <= RELEASE;
            rel_cnt <= RL;
            sustain_amt <= 1'b0;
          end
          RELEASE: if (trig) begin
            st <= ATTACK;
            hold_cnt <= HL;
            onset <= 1'b1;
            attack_amt <= 1'b1;
          end else if (rel_cnt == '0) st <= IDLE;
          else rel_cnt <= rel_cnt - 1'b1;
        endcase
      end
    end
  end
endmodule
